// File: rtl/multdiv_stall_ctrl.sv
// Stall/sequencing controller for the 5-stage core: load-use bubble insertion and
// start/freeze/release sequencing of the multi-cycle multdiv unit.
module multdiv_stall_ctrl #(
  parameter int MAX_CYCLES = 40,
  parameter int CNT_W      = 6
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] fd_ir,
  input  logic [31:0] dx_ir,
  input  logic        flush,
  input  logic        data_resultRDY,
  input  logic        data_exception,
  input  logic [31:0] data_result,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic        pc_we,
  output logic        fd_we,
  output logic        dx_we,
  output logic        dx_nop,
  output logic        xm_nop,
  output logic        md_result_sel,
  output logic [31:0] md_result,
  output logic        md_ovf,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_BEX   = 5'b10110;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        res_q, res_d;
  logic               ovf_q, ovf_d;

  logic [4:0] dx_op, dx_rd, dx_alu;
  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
  logic       dx_mul, dx_div, dx_lw;
  logic       fd_reads_rs, fd_reads_rt, fd_reads_rd, fd_bex;
  logic       load_use, md_start, timeout;
  logic       unused_bits;

  assign dx_op  = dx_ir[31:27];
  assign dx_rd  = dx_ir[26:22];
  assign dx_alu = dx_ir[6:2];
  assign fd_op  = fd_ir[31:27];
  assign fd_rd  = fd_ir[26:22];
  assign fd_rs  = fd_ir[21:17];
  assign fd_rt  = fd_ir[16:12];
  assign unused_bits = ^{fd_ir[11:0], dx_ir[21:7], dx_ir[1:0]};

  assign dx_mul = (dx_op == OP_RTYPE) && (dx_alu == ALU_MUL);
  assign dx_div = (dx_op == OP_RTYPE) && (dx_alu == ALU_DIV);
  assign dx_lw  = (dx_op == OP_LW);

  // sw reads rd as store data, but that path is covered by the WM bypass
  assign fd_reads_rs = (fd_op == OP_RTYPE) || (fd_op == OP_ADDI) || (fd_op == OP_LW) ||
                       (fd_op == OP_SW) || (fd_op == OP_BNE) || (fd_op == OP_BLT);
  assign fd_reads_rt = (fd_op == OP_RTYPE);
  assign fd_reads_rd = (fd_op == OP_BNE) || (fd_op == OP_BLT) || (fd_op == OP_JR);
  assign fd_bex      = (fd_op == OP_BEX);

  assign load_use = dx_lw && (dx_rd != 5'd0) &&
                    ((fd_reads_rs && (fd_rs == dx_rd)) ||
                     (fd_reads_rt && (fd_rt == dx_rd)) ||
                     (fd_reads_rd && (fd_rd == dx_rd)) ||
                     (fd_bex && (dx_rd == 5'd30)));

  assign md_start = (state_q == IDLE) && (dx_mul || dx_div) && !flush;
  assign timeout  = (cnt_q == CNT_W'(MAX_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (md_start) begin
          state_d = BUSY;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        // a result arriving on the final watchdog cycle still wins
        if (data_resultRDY) begin
          res_d   = data_result;
          ovf_d   = data_exception;
          state_d = DONE;
        end else if (timeout) begin
          res_d   = '0;
          ovf_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    ctrl_mult     = 1'b0;
    ctrl_div      = 1'b0;
    pc_we         = 1'b1;
    fd_we         = 1'b1;
    dx_we         = 1'b1;
    dx_nop        = 1'b0;
    xm_nop        = 1'b0;
    md_result_sel = 1'b0;
    // outputs sit at their reset values for the whole time reset is held
    if (reset_n) begin
      case (state_q)
        IDLE: begin
          if (md_start) begin
            ctrl_mult = dx_mul;
            ctrl_div  = dx_div;
            pc_we     = 1'b0;
            fd_we     = 1'b0;
            dx_we     = 1'b0;
            xm_nop    = 1'b1;
          end else if (!flush && load_use) begin
            pc_we  = 1'b0;
            fd_we  = 1'b0;
            dx_nop = 1'b1;
          end
        end
        BUSY: begin
          pc_we  = 1'b0;
          fd_we  = 1'b0;
          dx_we  = 1'b0;
          xm_nop = 1'b1;
        end
        DONE:    md_result_sel = 1'b1;
        default: ;
      endcase
    end
  end

  assign md_result = res_q;
  assign md_ovf    = ovf_q;
  assign busy      = (state_q == BUSY);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_multdiv_stall_ctrl.sv
// Directed bench for multdiv_stall_ctrl: reset, multdiv sequencing, watchdog,
// load-use detection and flush priority.
module tb_multdiv_stall_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] fd_ir, dx_ir, data_result;
  logic        flush, data_resultRDY, data_exception;
  logic        ctrl_mult, ctrl_div, pc_we, fd_we, dx_we, dx_nop, xm_nop;
  logic        md_result_sel, md_ovf, busy;
  logic [31:0] md_result;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h0;

  multdiv_stall_ctrl #(.MAX_CYCLES(40), .CNT_W(6)) dut (
    .clock(clock), .reset_n(reset_n), .fd_ir(fd_ir), .dx_ir(dx_ir), .flush(flush),
    .data_resultRDY(data_resultRDY), .data_exception(data_exception), .data_result(data_result),
    .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div), .pc_we(pc_we), .fd_we(fd_we), .dx_we(dx_we),
    .dx_nop(dx_nop), .xm_nop(xm_nop), .md_result_sel(md_result_sel), .md_result(md_result),
    .md_ovf(md_ovf), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] alu);
    return {5'b00000, rd, rs, rt, 5'b00000, alu, 2'b00};
  endfunction

  function automatic logic [31:0] itype(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Starts the op held in DX, fires RDY in BUSY cycle rdy_at (0 = never), ends in DONE.
  task automatic md_op(input string tag, input logic [31:0] ir, input bit is_div,
                       input int rdy_at, input logic [31:0] res, input logic exc,
                       input int exp_stalls, input logic [31:0] exp_res, input logic exp_ovf);
    int stalls;
    int bcycles;
    stalls  = 0;
    bcycles = 0;
    dx_ir = ir;
    #1;
    chk1({tag, "_start_mult"}, ctrl_mult, !is_div);
    chk1({tag, "_start_div"}, ctrl_div, is_div);
    chk1({tag, "_start_xm_nop"}, xm_nop, 1'b1);
    chk1({tag, "_start_dx_we"}, dx_we, 1'b0);
    while (pc_we == 1'b0 && stalls < 60) begin
      stalls++;
      if (busy) begin
        bcycles++;
        chk1({tag, "_no_repulse"}, ctrl_mult | ctrl_div, 1'b0);
        if (rdy_at != 0 && bcycles == rdy_at) begin
          data_resultRDY = 1'b1;
          data_result    = res;
          data_exception = exc;
        end
      end
      tick();
      data_resultRDY = 1'b0;
      data_exception = 1'b0;
      data_result    = 32'hFFFF_FFFF;
      #1;
    end
    chk32({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stalls));
    chk32({tag, "_done_state"}, 32'(dbg_state), 32'd2);
    chk1({tag, "_done_sel"}, md_result_sel, 1'b1);
    chk1({tag, "_done_xm_nop"}, xm_nop, 1'b0);
    chk1({tag, "_done_no_pulse"}, ctrl_mult | ctrl_div, 1'b0);
    chk32({tag, "_done_result"}, md_result, exp_res);
    chk1({tag, "_done_ovf"}, md_ovf, exp_ovf);
  endtask

  // One IDLE cycle of load-use detection.
  task automatic lu(input string tag, input logic [31:0] dx, input logic [31:0] fd,
                    input logic fl, input logic exp_stall);
    dx_ir = dx;
    fd_ir = fd;
    flush = fl;
    #1;
    chk1({tag, "_pc_we"}, pc_we, !exp_stall);
    chk1({tag, "_fd_we"}, fd_we, !exp_stall);
    chk1({tag, "_dx_nop"}, dx_nop, exp_stall);
    chk1({tag, "_dx_we"}, dx_we, 1'b1);
    tick();
    flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] mul_ir, div_ir, lw_r5;
    mul_ir = rtype(5'd3, 5'd1, 5'd2, 5'b00110);
    div_ir = rtype(5'd4, 5'd1, 5'd0, 5'b00111);
    lw_r5  = itype(5'b01000, 5'd5, 5'd1, 17'd0);

    // reset with a mul sitting in DX: no pulse, reset output values
    reset_n = 1'b0; flush = 1'b0; data_resultRDY = 1'b0; data_exception = 1'b0;
    data_result = '0; fd_ir = NOP; dx_ir = mul_ir;
    #1;
    chk32("rst_state", 32'(dbg_state), 32'd0);
    chk1("rst_ctrl_mult", ctrl_mult, 1'b0);
    chk1("rst_pc_we", pc_we, 1'b1);
    chk1("rst_fd_we", fd_we, 1'b1);
    chk1("rst_dx_we", dx_we, 1'b1);
    chk1("rst_xm_nop", xm_nop, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk32("rst_md_result", md_result, 32'h0);
    chk1("rst_md_ovf", md_ovf, 1'b0);
    tick();
    dx_ir = NOP;
    reset_n = 1'b1;
    tick();

    // mul, RDY in 4th BUSY cycle: 5 stall cycles
    md_op("mul", mul_ir, 1'b0, 4, 32'h0000_0032, 1'b0, 5, 32'h0000_0032, 1'b0);
    // FD holds a div during DONE: no pulse until it reaches DX
    fd_ir = div_ir;
    #1;
    chk1("b2b_done_no_div", ctrl_div, 1'b0);
    tick();
    fd_ir = NOP;
    chk32("b2b_idle_state", 32'(dbg_state), 32'd0);
    md_op("div0", div_ir, 1'b1, 2, 32'hDEAD_BEEF, 1'b1, 3, 32'hDEAD_BEEF, 1'b1);
    tick();
    dx_ir = NOP;

    // RDY outside BUSY is ignored
    data_resultRDY = 1'b1; data_result = 32'h0000_0BAD; data_exception = 1'b0;
    tick();
    data_resultRDY = 1'b0;
    #1;
    chk32("idle_rdy_result", md_result, 32'hDEAD_BEEF);
    chk1("idle_rdy_ovf", md_ovf, 1'b1);
    chk32("idle_rdy_state", 32'(dbg_state), 32'd0);

    // asynchronous reset in the middle of BUSY
    dx_ir = mul_ir;
    tick();
    tick();
    chk1("pre_rst_busy", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    chk32("midrst_state", 32'(dbg_state), 32'd0);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_pc_we", pc_we, 1'b1);
    chk1("midrst_xm_nop", xm_nop, 1'b0);
    chk32("midrst_result", md_result, 32'h0);
    chk1("midrst_ovf", md_ovf, 1'b0);
    dx_ir = NOP;
    tick();
    reset_n = 1'b1;
    tick();

    // watchdog: 40 BUSY cycles then forced exception
    md_op("tmo", mul_ir, 1'b0, 0, 32'h0, 1'b0, 41, 32'h0, 1'b1);
    tick();
    dx_ir = NOP;
    tick();
    // RDY on the final watchdog cycle wins
    md_op("tmo_rdy", div_ir, 1'b1, 40, 32'h0000_1234, 1'b0, 41, 32'h0000_1234, 1'b0);
    tick();
    dx_ir = NOP;
    tick();

    // load-use detection
    lu("lu_add_rs", lw_r5, rtype(5'd6, 5'd5, 5'd7, 5'b00000), 1'b0, 1'b1);
    lu("lu_after_bubble", NOP, rtype(5'd6, 5'd5, 5'd7, 5'b00000), 1'b0, 1'b0);
    lu("lu_add_rt", lw_r5, rtype(5'd6, 5'd7, 5'd5, 5'b00000), 1'b0, 1'b1);
    lu("lu_add_none", lw_r5, rtype(5'd5, 5'd7, 5'd8, 5'b00000), 1'b0, 1'b0);
    lu("lu_sw_data", lw_r5, itype(5'b00111, 5'd5, 5'd8, 17'd0), 1'b0, 1'b0);
    lu("lu_sw_base", lw_r5, itype(5'b00111, 5'd9, 5'd5, 17'd4), 1'b0, 1'b1);
    lu("lu_addi", lw_r5, itype(5'b00101, 5'd9, 5'd5, 17'd1), 1'b0, 1'b1);
    lu("lu_bne_rd", lw_r5, itype(5'b00010, 5'd5, 5'd9, 17'd3), 1'b0, 1'b1);
    lu("lu_jr", lw_r5, {5'b00100, 5'd5, 22'd0}, 1'b0, 1'b1);
    lu("lu_r0", itype(5'b01000, 5'd0, 5'd1, 17'd0), rtype(5'd6, 5'd0, 5'd0, 5'b00000), 1'b0, 1'b0);
    lu("lu_flush", lw_r5, rtype(5'd6, 5'd5, 5'd7, 5'b00000), 1'b1, 1'b0);
    lu("lu_bex_r5", lw_r5, {5'b10110, 27'd100}, 1'b0, 1'b0);
    lu("lu_bex_r30", itype(5'b01000, 5'd30, 5'd1, 17'd0), {5'b10110, 27'd100}, 1'b0, 1'b1);

    // flush beats a multdiv start
    dx_ir = mul_ir; fd_ir = NOP; flush = 1'b1;
    #1;
    chk1("flush_no_mult", ctrl_mult, 1'b0);
    chk1("flush_pc_we", pc_we, 1'b1);
    chk1("flush_xm_nop", xm_nop, 1'b0);
    tick();
    flush = 1'b0; dx_ir = NOP;
    #1;
    chk1("flush_not_busy", busy, 1'b0);
    chk32("flush_state", 32'(dbg_state), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
